// File: rtl/lsu_if.sv
// Request/response and dcache signal bundle for the load/store sequencer.
// The slave modport is the sequencer's view; master is the core/dcache side.
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic                  dc_we;
  logic [3:0]            dc_be;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic [DATA_WIDTH-1:0] dc_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dc_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dc_addr, dc_we, dc_be, dc_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dc_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dc_addr, dc_we, dc_be, dc_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one RV32 access in flight, sub-word encoding toward
// dcache, fixed-latency read wait and load extraction/extension.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  lsu
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  capture;

  logic                  we_p0;
  logic [2:0]            f3_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;

  function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] o);
    logic ill;
    logic mis;
    if (we) ill = (f3 > 3'd2);
    else    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    case (f3[1:0])
      2'b01:   mis = o[0];
      2'b10:   mis = |o;
      default: mis = 1'b0;
    endcase
    return ill | mis;
  endfunction

  function automatic logic [3:0] be_enc(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wdata_enc(input logic [2:0] f3,
                                                      input logic [DATA_WIDTH-1:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                                     input logic [DATA_WIDTH-1:0] rd);
    logic        [DATA_WIDTH-1:0] s;
    logic signed [7:0]            sb;
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] sx;
    s  = rd >> {o, 3'b000};
    sb = s[7:0];
    sh = s[15:0];
    case (f3)
      3'b000:  begin sx = DATA_WIDTH'(sb); return sx; end
      3'b001:  begin sx = DATA_WIDTH'(sh); return sx; end
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  assign accept = (state_q == IDLE) && lsu.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Accept stage: request fields latched; they are only qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= lsu.req_we;
      f3_p0    <= lsu.req_funct3;
      addr_p0  <= lsu.req_addr;
      wdata_p0 <= lsu.req_wdata;
    end
    // Capture stage: load data extracted as it leaves dcache.
    if (capture) rdata_p1 <= load_ext(f3_p0, addr_p0[1:0], lsu.dc_rdata);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          err_d   = bad_req(lsu.req_we, lsu.req_funct3, lsu.req_addr[1:0]);
          state_d = err_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (we_p0) begin
          state_d = RESP;
        end else if (LAT == 2'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          // The ISSUE edge is the first of the RD_LATENCY edges.
          cnt_d   = 2'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (lsu.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lsu.req_ready = (state_q == IDLE);
  assign lsu.rsp_valid = (state_q == RESP);
  assign lsu.rsp_err   = (state_q == RESP) && err_q;
  assign lsu.rsp_rdata = ((state_q == RESP) && !err_q && !we_p0) ? rdata_p1 : '0;
  assign lsu.dc_we     = (state_q == ISSUE) && we_p0;
  assign lsu.dc_be     = lsu.dc_we ? be_enc(f3_p0, addr_p0[1:0]) : 4'b0000;
  assign lsu.dc_wdata  = lsu.dc_we ? wdata_enc(f3_p0, wdata_p0) : '0;
  assign lsu.dc_addr   = ((state_q == ISSUE) || (state_q == WAIT)) ?
                         {addr_p0[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's memory stage and `dcache`. It accepts one load or store request at a time over a valid/ready handshake and encodes RV32 sub-word accesses into the word-aligned address, byte-enable and replicated write data that `dcache` expects. It waits out the configurable `dcache` read latency, then extracts and sign- or zero-extends load data. Misaligned or illegal requests are answered with an error and never reach `dcache`.

## Interface
- `DATA_WIDTH`, 32: data width; only 32 supported.
- `ADDR_WIDTH`, 32: byte address width.
- `RD_LATENCY`, 2: edges from `dcache` read address presented to `dc_rdata` valid. Legal values: 0 (simulation model, combinational read) to 3. The SRAM build uses 2.

Ports:
- `clk`  in  1  sole clock; all flops on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_we`  in  1  0 = load, 1 = store.
- `req_funct3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal funct3.
- `dc_addr`  out  ADDR_WIDTH  `{req_addr[ADDR_WIDTH-1:2], 2'b00}`.
- `dc_we`  out  1  to `dcache` `we_i`.
- `dc_be`  out  4  to `dcache` `be_i`.
- `dc_wdata`  out  DATA_WIDTH  to `dcache` `data_i`.
- `dc_rdata`  in  DATA_WIDTH  from `dcache` `data_o`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. `req_ready` = (state == IDLE).
- **IDLE:** on `req_valid`, the block latches `req_*`.
  - An illegal or misaligned request goes to RESP with `rsp_err`=1.
  - Any other request goes to ISSUE.
- **Illegal funct3:** loads 011, 110, 111; stores 011–111.
- **Misaligned:** a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- **ISSUE** lasts exactly one cycle, with `dc_addr` valid.
  - A store drives `dc_we`=1 and then goes to RESP.
  - A load drives `dc_we`=0 and `dc_be`=0. With `RD_LATENCY`=0 it captures `dc_rdata` in this cycle and goes to RESP; otherwise it goes to WAIT.
- **WAIT:** counts `RD_LATENCY` edges starting from the ISSUE edge, holding `dc_addr` stable. When the count is reached it captures `dc_rdata` and goes to RESP.
- **RESP:** `rsp_valid`=1, with `rsp_*` held stable until `rsp_ready`. Then the FSM returns to IDLE.
- **Store encoding** (with o = `addr[1:0]`):
  - SB: `dc_be` = 4'b0001<<o, `dc_wdata` = `{4{wdata[7:0]}}`.
  - SH: `dc_be` = 4'b0011<<o, `dc_wdata` = `{2{wdata[15:0]}}`.
  - SW: `dc_be` = 4'b1111, `dc_wdata` = wdata.
- **Load extraction:** s = `dc_rdata` >> (8·o).
  - LB / LBU: sign- / zero-extend `s[7:0]`.
  - LH / LHU: sign- / zero-extend `s[15:0]`.
  - LW: `dc_rdata`.
- `dc_we` and `dc_be` are 0 in every state except a store ISSUE.
- The block never has more than one request in flight.

## Timing
- **Reset values** (held while `rst_n`=0, for every output):
  - State IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `dc_addr`=0, `dc_we`=0, `dc_be`=0, `dc_wdata`=0.
- **Latencies** (accept edge E0; counted to the first cycle with `rsp_valid`=1):
  - Store: ISSUE in cycle E0+1, write commits at edge E1, `rsp_valid` from E2.
  - Load: `rsp_valid` from edge E(2+`RD_LATENCY`).
  - Error: `rsp_valid` from E1, with no `dcache` activity.
- **Back-to-back:** the response handshake at edge Ek returns the FSM to IDLE, and the next request is accepted no earlier than edge Ek+1. Minimum store period is 3 cycles.
- **Backpressure:** `rsp_ready` low extends RESP indefinitely, and `dc_we` stays 0 throughout.
- **Reset mid-operation:** the FSM returns to IDLE immediately and `dc_we` drops asynchronously. A write being issued at that moment leaves the memory word undefined. No response is produced for the aborted request.
- `req_*` inputs are sampled only at the accept edge; they may change afterwards.

## Test plan
- **Aligned SW then LW:** SW addr 0x10 data 0xA0B0C0D0 → one ISSUE cycle with `dc_be`=1111, `rsp_err`=0. Then LW 0x10 → `rsp_rdata`=0xA0B0C0D0, `rsp_valid` exactly 2+`RD_LATENCY` cycles after accept.
- **Sub-word stores:** SB 0x13 data 0x80 → `dc_be`=1000, `dc_wdata`=0x80808080. SH 0x12 data 0x1234 → `dc_be`=1100.
- **Loads from 0x13 holding 0x80:** LB → 0xFFFFFF80; LBU → 0x00000080. LH 0x12 over bytes 0x80,0x34 → 0xFFFF8034.
- **Errors:** LW 0x11, SH 0x13 and load funct3 011 → `rsp_err`=1, `rsp_rdata`=0, `dc_we` never asserted, response 1 cycle after accept.
- **Backpressure and throughput:** `rsp_ready` held low 5 cycles → `rsp_*` stable and `req_ready`=0. Release it → the next request is accepted on the following edge.
- **Reset mid-load:** assert `rst_n`=0 during WAIT → all outputs take their reset values immediately, no `rsp_valid`. After release a fresh LW completes normally.
- **Parameter sweep:** repeat the load scenarios for `RD_LATENCY` = 0, 1, 2, 3.
